// File: rtl/chunk_builder.sv
// Byte-wise MD5 message block builder: collects up to MAX_LEN bytes,
// appends MD5 padding and length, and serves words to the round engine.
module chunk_builder #(
  parameter int MAX_LEN = 55
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  char_data,
  input  logic        char_valid,
  input  logic        char_last,
  output logic        char_ready,
  output logic        block_valid,
  input  logic        consume,
  input  logic [3:0]  gaddr,
  output logic [31:0] mdata,
  output logic [5:0]  msg_len,
  output logic        overflow
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] PAD   = 2'd2;
  localparam logic [1:0] READY = 2'd3;

  localparam logic [5:0] MAX = 6'(MAX_LEN);

  logic [1:0]  state;
  logic [31:0] w [16];
  logic        take;
  logic        hit_max;
  logic [3:0]  widx;
  logic [4:0]  lane;

  assign char_ready  = (state == IDLE) || (state == LOAD);
  assign block_valid = (state == READY);
  assign take        = char_valid & char_ready;
  assign hit_max     = (msg_len + 6'd1) == MAX;
  assign widx        = msg_len[5:2];
  assign lane        = {msg_len[1:0], 3'b000};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      mdata    <= '0;
      msg_len  <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        w[i] <= '0;
      end
    end else begin
      mdata <= w[gaddr];
      case (state)
        IDLE, LOAD: begin
          if (take) begin
            w[widx][lane +: 8] <= char_data;
            msg_len <= msg_len + 6'd1;
            if (char_last) begin
              state <= PAD;
            end else if (hit_max) begin
              state    <= PAD;
              overflow <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        PAD: begin
          // 0x80 marker lands right after the last message byte
          w[widx][lane +: 8] <= 8'h80;
          w[14] <= {23'b0, msg_len, 3'b000};
          w[15] <= '0;
          state <= READY;
        end
        READY: begin
          if (consume) begin
            state    <= IDLE;
            msg_len  <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < 16; i++) begin
              w[i] <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunk_builder.sv
// Directed table-driven bench for chunk_builder.
// Vectors carry hand-computed word values; extra sequences cover reset and overflow.
module tb_chunk_builder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  char_data;
  logic        char_valid;
  logic        char_last;
  logic        char_ready;
  logic        block_valid;
  logic        consume;
  logic [3:0]  gaddr;
  logic [31:0] mdata;
  logic [5:0]  msg_len;
  logic        overflow;

  int tests = 0;
  int fails = 0;

  chunk_builder #(.MAX_LEN(55)) dut (
    .clk(clk), .reset_n(reset_n),
    .char_data(char_data), .char_valid(char_valid),
    .char_last(char_last), .char_ready(char_ready),
    .block_valid(block_valid), .consume(consume),
    .gaddr(gaddr), .mdata(mdata),
    .msg_len(msg_len), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          len;
    logic [7:0]  base;
    logic [7:0]  step;
    logic        last;
    int          ia;
    logic [31:0] wa;
    int          ib;
    logic [31:0] wb;
    logic [5:0]  elen;
    logic        eovf;
  } vec_t;

  vec_t vecs [5];
  logic [31:0] expw [16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    @(negedge clk);
    char_data  = d;
    char_last  = l;
    char_valid = 1'b1;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    char_last  = 1'b0;
  endtask

  task automatic rd(input int k, output logic [31:0] v);
    @(negedge clk);
    gaddr = 4'(k);
    @(negedge clk);
    v = mdata;
  endtask

  task automatic model(input int len, input logic [7:0] base,
                       input logic [7:0] step);
    for (int i = 0; i < 16; i++) expw[i] = '0;
    for (int n = 0; n < len; n++)
      expw[n/4][8*(n%4) +: 8] = base + 8'(n) * step;
    expw[len/4][8*(len%4) +: 8] = 8'h80;
    expw[14] = 32'(len * 8);
  endtask

  task automatic chk_all(input string nm);
    logic [31:0] v;
    int bad;
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      rd(k, v);
      if (v !== expw[k]) begin
        bad++;
        $display("FAIL %s word %0d: got %h expected %h", nm, k, v, expw[k]);
      end
    end
    tests++;
    if (bad != 0) fails++;
  endtask

  task automatic do_consume(input string nm);
    logic [31:0] v;
    int bad;
    @(negedge clk);
    consume = 1'b1;
    chk({nm, " ready_on_consume"}, 32'(char_ready), 32'd0);
    @(posedge clk);
    #1;
    consume = 1'b0;
    chk({nm, " idle_ready"}, 32'(char_ready), 32'd1);
    chk({nm, " idle_valid"}, 32'(block_valid), 32'd0);
    chk({nm, " idle_len"}, 32'(msg_len), 32'd0);
    chk({nm, " idle_ovf"}, 32'(overflow), 32'd0);
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      rd(k, v);
      if (v !== 32'd0) bad++;
    end
    chk({nm, " cleared_words"}, 32'(bad), 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    vecs[0] = '{"abc", 3, 8'h61, 8'h01, 1'b1,
                0, 32'h80636261, 14, 32'h00000018, 6'd3, 1'b0};
    vecs[1] = '{"zero1", 1, 8'h00, 8'h00, 1'b1,
                0, 32'h00008000, 14, 32'h00000008, 6'd1, 1'b0};
    vecs[2] = '{"a55last", 55, 8'h41, 8'h00, 1'b1,
                13, 32'h80414141, 14, 32'h000001B8, 6'd55, 1'b0};
    vecs[3] = '{"a55cut", 55, 8'h41, 8'h00, 1'b0,
                13, 32'h80414141, 14, 32'h000001B8, 6'd55, 1'b1};
    vecs[4] = '{"four", 4, 8'h11, 8'h11, 1'b1,
                0, 32'h44332211, 1, 32'h00000080, 6'd4, 1'b0};

    reset_n    = 1'b0;
    char_data  = '0;
    char_valid = 1'b0;
    char_last  = 1'b0;
    consume    = 1'b0;
    gaddr      = '0;
    #2;
    chk("rst_valid", 32'(block_valid), 32'd0);
    chk("rst_len", 32'(msg_len), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_mdata", mdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready", 32'(char_ready), 32'd1);

    // consume outside READY must be ignored
    send(8'h61, 1'b0);
    @(negedge clk);
    consume = 1'b1;
    @(posedge clk);
    #1;
    consume = 1'b0;
    chk("load_consume_len", 32'(msg_len), 32'd1);
    chk("load_consume_ready", 32'(char_ready), 32'd1);
    send(8'h62, 1'b0);
    send(8'h63, 1'b1);
    model(3, 8'h61, 8'h01);
    chk("pre_abc_pad", 32'(block_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("pre_abc_ready", 32'(block_valid), 32'd1);
    chk_all("pre_abc");
    do_consume("pre_abc");

    for (int t = 0; t < 5; t++) begin
      for (int n = 0; n < vecs[t].len; n++)
        send(vecs[t].base + 8'(n) * vecs[t].step,
             vecs[t].last && (n == vecs[t].len - 1));
      chk({vecs[t].name, " pad_cycle"}, 32'(block_valid), 32'd0);
      chk({vecs[t].name, " pad_ready"}, 32'(char_ready), 32'd0);
      if (!vecs[t].last) begin
        // a further byte offered while not ready must be dropped
        @(negedge clk);
        char_data  = 8'h5A;
        char_valid = 1'b1;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
      end else begin
        @(posedge clk);
        #1;
      end
      chk({vecs[t].name, " valid"}, 32'(block_valid), 32'd1);
      chk({vecs[t].name, " len"}, 32'(msg_len), 32'(vecs[t].elen));
      chk({vecs[t].name, " ovf"}, 32'(overflow), 32'(vecs[t].eovf));
      rd(vecs[t].ia, v);
      chk({vecs[t].name, " wa"}, v, vecs[t].wa);
      rd(vecs[t].ib, v);
      chk({vecs[t].name, " wb"}, v, vecs[t].wb);
      model(vecs[t].len, vecs[t].base, vecs[t].step);
      chk_all(vecs[t].name);
      chk({vecs[t].name, " still_valid"}, 32'(block_valid), 32'd1);
      do_consume(vecs[t].name);
    end

    // asynchronous reset in the middle of a message
    send(8'h78, 1'b0);
    send(8'h79, 1'b0);
    @(negedge clk);
    gaddr = 4'd0;
    @(posedge clk);
    #1;
    chk("mid_mdata", mdata, 32'h00007978);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_len", 32'(msg_len), 32'd0);
    chk("async_mdata", mdata, 32'd0);
    chk("async_valid", 32'(block_valid), 32'd0);
    chk("async_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    send(8'h63, 1'b1);
    @(posedge clk);
    #1;
    chk("post_rst_valid", 32'(block_valid), 32'd1);
    chk("post_rst_len", 32'(msg_len), 32'd3);
    model(3, 8'h61, 8'h01);
    chk_all("post_rst_abc");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/chunk_builder.md
CHUNK_BUILDER -- requirements
Module: chunk_builder

Interface
REQ-001 SHALL have parameter MAX_LEN, default 55, the maximum message length in bytes; the legal range is 1..55.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port char_data, input, 8 bits: the message byte offered.
REQ-005 SHALL have port char_valid, input, 1 bit: char_data is valid.
REQ-006 SHALL have port char_last, input, 1 bit: the offered byte is the final byte of the message.
REQ-007 SHALL have port char_ready, output, 1 bit: the block can accept a byte this cycle.
REQ-008 SHALL have port block_valid, output, 1 bit: the padded 512-bit block is complete and stable.
REQ-009 SHALL have port consume, input, 1 bit: single-cycle pulse releasing the block once the digest is taken.
REQ-010 SHALL have port gaddr, input, 4 bits: word index from the MD5 round engine.
REQ-011 SHALL have port mdata, output, 32 bits: the word selected by gaddr, registered.
REQ-012 SHALL have port msg_len, output, 6 bits: the number of bytes accepted for the current message.
REQ-013 SHALL have port overflow, output, 1 bit: the message was cut at MAX_LEN without char_last.

Function
REQ-014 SHALL hold sixteen 32-bit words, W0..W15.
REQ-015 SHALL use exactly four states: IDLE, LOAD, PAD, READY.
REQ-016 SHALL drive char_ready=1 only in IDLE and LOAD.
REQ-017 SHALL accept a byte only on a cycle where char_valid and char_ready are both 1.
REQ-018 SHALL store byte n (0-based) in word n/4, bits [8*(n%4)+7 : 8*(n%4)] (little-endian lanes), and increment msg_len.
REQ-019 SHALL transition IDLE->LOAD on the first accepted byte, with the byte stored that same cycle.
REQ-020 SHALL transition IDLE/LOAD->PAD when the accepted byte has char_last=1.
REQ-021 SHALL also transition to PAD when the accepted byte makes msg_len=MAX_LEN with char_last=0, and SHALL set overflow=1 in that case.
REQ-022 SHALL, in PAD (exactly one cycle): write 0x80 at byte position msg_len; set W14 = {23'b0, msg_len, 3'b0} (length in bits); set W15 = 0; then transition to READY.
REQ-023 SHALL keep every unwritten byte at zero.
REQ-024 SHALL drive block_valid=1 only in READY.
REQ-025 SHALL keep W0..W15 unchanged while in READY.
REQ-026 SHALL, on consume in READY: clear W0..W15, msg_len and overflow in one cycle, and go to IDLE.
REQ-027 SHALL drive char_ready=0 on the consume cycle.
REQ-028 SHALL ignore consume in IDLE, LOAD and PAD.
REQ-029 SHALL register mdata as mdata <= W[gaddr] on every edge, in all states (one-cycle read latency).
REQ-030 SHALL guarantee that a gaddr held for 2 cycles yields the correct word.
REQ-031 SHALL ignore char_valid while char_ready=0; the byte is not consumed.
REQ-032 SHALL keep msg_len within 0..MAX_LEN; it never wraps.

Reset
REQ-033 SHALL, when reset_n=0, immediately and asynchronously set: state=IDLE; W0..W15=0; mdata=0; msg_len=0; overflow=0; block_valid=0.
REQ-034 SHALL drive char_ready=1 from the first edge after reset_n deasserts.
REQ-035 SHALL abort any partial message or valid block on reset mid-operation, with no residue.

Verification
REQ-036 SHALL pass: bytes 'a','b','c' (last on 'c') -> PAD 1 cycle, then block_valid=1; W0=0x80636261, W14=0x00000018, all other words 0; msg_len=3; overflow=0.
REQ-037 SHALL pass: single byte 0x00 with last -> W0=0x00008000, W14=0x00000008.
REQ-038 SHALL pass: 55 bytes 0x41 (last on the 55th) -> W13=0x80414141, W14=0x000001B8; overflow=0.
REQ-039 SHALL pass: 55 bytes with no last -> PAD after the 55th; overflow=1; char_ready=0; a 56th char_valid is not accepted.
REQ-040 SHALL pass: in READY, sweep gaddr 0..15 -> mdata equals W[gaddr] one cycle later; consume -> next cycle IDLE, all words read 0, char_ready=1.
REQ-041 SHALL pass: reset_n pulsed low mid-LOAD (asynchronously, between edges) -> outputs at reset values immediately; a following "abc" yields the same block as REQ-036.
